ptr_reg_bank: RTL and testbench

Parametrised bank of NCH independent pointer registers (row/column/stack-style pointers) for the processor datapath. Each channel holds a current pointer, a base, and a limit. It supports bus load, rewind-to-base, increment and decrement, with wrap between base and limit and a one-cycle wrap pulse. The bank sits on the main bus in the same position as the existing single pointer registers and replaces them with one configurable block.

---
 rtl/ptr_bank_pkg.sv | 30 +++
 rtl/ptr_channel.sv | 121 ++++++++++++
 rtl/ptr_reg_bank.sv | 73 +++++++
 tb/tb_ptr_reg_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptr_bank_pkg.sv
// Shared definitions for the pointer register bank: bus write-target codes and per-channel op encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ptr_bank_pkg;

    // Wmode write-target codes
    localparam logic [1:0] WM_PTR  = 2'b00;
    localparam logic [1:0] WM_BASE = 2'b01;
    localparam logic [1:0] WM_LIM  = 2'b10;
    localparam logic [1:0] WM_NOP  = 2'b11;

    // Operation a channel performs on a given edge, after priority resolution
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_REW  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } ptr_op_e;

    // True when a Wmode code targets a register that exists in this build
    function automatic logic wmode_is_write(input logic [1:0] wm);
`ifdef PTRBANK_WRAP_EN
        return (wm != WM_NOP);
`else
        return (wm == WM_PTR) || (wm == WM_BASE);
`endif
    endfunction

endpackage

// File: rtl/ptr_channel.sv
// One pointer channel: pointer/base/limit registers, priority resolution, wrap pulse (PTRBANK_WRAP_EN selects base/limit wrap).
// Latency: every request takes effect on the next rising Clk edge; outputs are registered.
// Backpressure: none; every request is accepted on the edge it is sampled.
module ptr_channel
    import ptr_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             wr_ptr,
    input  logic             wr_base,
`ifdef PTRBANK_WRAP_EN
    input  logic             wr_lim,
`endif
    input  logic             rew,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] ptr,
    output logic             base_valid,
    output logic             wrap
);

    logic [WIDTH-1:0] base;
    logic             wr_any;
    logic             at_top;    // Inc from here wraps
    logic             at_bot;    // Dec from here wraps
    logic [WIDTH-1:0] top_val;   // value Dec wraps to
    logic [WIDTH-1:0] bot_val;   // value Inc wraps to
    ptr_op_e          op;

`ifdef PTRBANK_WRAP_EN
    logic [WIDTH-1:0] lim;

    assign wr_any  = wr_ptr | wr_base | wr_lim;
    assign at_top  = (ptr == lim);
    assign at_bot  = (ptr == base);
    assign top_val = lim;
    assign bot_val = base;
`else
    // Without limit registers the wrap points are the arithmetic rollover points
    assign wr_any  = wr_ptr | wr_base;
    assign at_top  = &ptr;
    assign at_bot  = ~|ptr;
    assign top_val = '1;
    assign bot_val = '0;
`endif

    // Resolve this edge's operation: write > rewind > inc/dec (both together cancel) > hold
    always_comb begin
        op = OP_HOLD;
        if (wr_any) begin
            op = OP_LOAD;
        end else if (rew) begin
            op = OP_REW;
        end else if (inc && !dec) begin
            op = OP_INC;
        end else if (dec && !inc) begin
            op = OP_DEC;
        end
    end

    // Register update; wrap is a one-cycle pulse so it defaults low every edge
    always_ff @(posedge Clk) begin
        if (RST) begin
            ptr        <= '0;
            base       <= '0;
            base_valid <= 1'b0;
            wrap       <= 1'b0;
`ifdef PTRBANK_WRAP_EN
            lim        <= '1;
`endif
        end else begin
            wrap <= 1'b0;
            case (op)
                OP_LOAD: begin
                    if (wr_ptr) begin
                        ptr <= din;
                        // The first pointer load after reset also defines the rewind point
                        if (!base_valid) begin
                            base       <= din;
                            base_valid <= 1'b1;
                        end
                    end
                    if (wr_base) begin
                        base       <= din;
                        base_valid <= 1'b1;
                    end
`ifdef PTRBANK_WRAP_EN
                    if (wr_lim) begin
                        lim <= din;
                    end
`endif
                end
                OP_REW: begin
                    ptr <= base;
                end
                OP_INC: begin
                    if (at_top) begin
                        ptr  <= bot_val;
                        wrap <= 1'b1;
                    end else begin
                        ptr <= ptr + WIDTH'(1);
                    end
                end
                OP_DEC: begin
                    if (at_bot) begin
                        ptr  <= top_val;
                        wrap <= 1'b1;
                    end else begin
                        ptr <= ptr - WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ptr_reg_bank.sv
// Bank of NCH pointer registers on the main bus; decodes bus writes into per-channel strobes (PTRBANK_WRAP_EN enables limit wrap).
// Latency: one Clk edge from request to dout/base_valid/wrap; no combinational input-to-output path.
// Backpressure: none; writes and Rew/Inc/Dec are always accepted.
module ptr_reg_bank
    import ptr_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 Clk,
    input  logic                 RST,
    input  logic                 Wen,
    input  logic [SEL_W-1:0]     Wsel,
    input  logic [1:0]           Wmode,
    input  logic [WIDTH-1:0]     BusOut,
    input  logic [NCH-1:0]       Rew,
    input  logic [NCH-1:0]       Inc,
    input  logic [NCH-1:0]       Dec,
    output logic [NCH*WIDTH-1:0] dout,
    output logic [NCH-1:0]       base_valid,
    output logic [NCH-1:0]       wrap
);

    logic [NCH-1:0] wr_ptr_v;
    logic [NCH-1:0] wr_base_v;
`ifdef PTRBANK_WRAP_EN
    logic [NCH-1:0] wr_lim_v;
`endif

    // Decode the bus write into per-channel target strobes; Wsel >= NCH or a no-op Wmode raises none
    always_comb begin
        wr_ptr_v  = '0;
        wr_base_v = '0;
`ifdef PTRBANK_WRAP_EN
        wr_lim_v  = '0;
`endif
        for (int k = 0; k < NCH; k++) begin
            if (Wen && (Wsel == SEL_W'(k)) && wmode_is_write(Wmode)) begin
                wr_ptr_v[k]  = (Wmode == WM_PTR);
                wr_base_v[k] = (Wmode == WM_BASE);
`ifdef PTRBANK_WRAP_EN
                wr_lim_v[k]  = (Wmode == WM_LIM);
`endif
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            ptr_channel #(
                .WIDTH      (WIDTH)
            ) u_ch (
                .Clk        (Clk),
                .RST        (RST),
                .wr_ptr     (wr_ptr_v[k]),
                .wr_base    (wr_base_v[k]),
`ifdef PTRBANK_WRAP_EN
                .wr_lim     (wr_lim_v[k]),
`endif
                .rew        (Rew[k]),
                .inc        (Inc[k]),
                .dec        (Dec[k]),
                .din        (BusOut),
                .ptr        (dout[k*WIDTH +: WIDTH]),
                .base_valid (base_valid[k]),
                .wrap       (wrap[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ptr_reg_bank.sv
// Self-checking bench for ptr_reg_bank: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model state is compared 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_ptr_reg_bank;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int SEL_W = 2;
    localparam int MOD   = 1 << WIDTH;

    logic                 Clk = 1'b0;
    logic                 RST;
    logic                 Wen;
    logic [SEL_W-1:0]     Wsel;
    logic [1:0]           Wmode;
    logic [WIDTH-1:0]     BusOut;
    logic [NCH-1:0]       Rew;
    logic [NCH-1:0]       Inc;
    logic [NCH-1:0]       Dec;
    logic [NCH*WIDTH-1:0] dout;
    logic [NCH-1:0]       base_valid;
    logic [NCH-1:0]       wrap;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference state
    int m_ptr  [NCH];
    int m_base [NCH];
    int m_lim  [NCH];
    bit m_bv   [NCH];
    bit m_wrap [NCH];

    always #5 Clk = ~Clk;

    ptr_reg_bank #(
        .WIDTH      (WIDTH),
        .NCH        (NCH),
        .SEL_W      (SEL_W)
    ) dut (
        .Clk        (Clk),
        .RST        (RST),
        .Wen        (Wen),
        .Wsel       (Wsel),
        .Wmode      (Wmode),
        .BusOut     (BusOut),
        .Rew        (Rew),
        .Inc        (Inc),
        .Dec        (Dec),
        .dout       (dout),
        .base_valid (base_valid),
        .wrap       (wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ch_dout(input int ch);
        logic [WIDTH-1:0] v;
        v = dout[ch*WIDTH +: WIDTH];
        return 32'(v);
    endfunction

    function automatic bit write_exists(input int wmode);
`ifdef PTRBANK_WRAP_EN
        return wmode != 3;
`else
        return wmode == 0 || wmode == 1;
`endif
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_ptr[ch]  = 0;
            m_base[ch] = 0;
            m_lim[ch]  = MOD - 1;
            m_bv[ch]   = 0;
            m_wrap[ch] = 0;
        end
    endfunction

    function automatic void model_step(input bit wen, input int wsel, input int wmode, input int data,
                                       input bit [NCH-1:0] rew, input bit [NCH-1:0] inc, input bit [NCH-1:0] dec);
        for (int ch = 0; ch < NCH; ch++) begin
            m_wrap[ch] = 0;
            if (wen && wsel == ch && write_exists(wmode)) begin
                if (wmode == 0) begin
                    m_ptr[ch] = data;
                    if (!m_bv[ch]) begin
                        m_base[ch] = data;
                        m_bv[ch]   = 1;
                    end
                end else if (wmode == 1) begin
                    m_base[ch] = data;
                    m_bv[ch]   = 1;
                end else begin
                    m_lim[ch] = data;
                end
            end else if (rew[ch]) begin
                m_ptr[ch] = m_base[ch];
            end else if (inc[ch] && !dec[ch]) begin
`ifdef PTRBANK_WRAP_EN
                if (m_ptr[ch] == m_lim[ch]) begin
                    m_ptr[ch]  = m_base[ch];
                    m_wrap[ch] = 1;
                end else begin
                    m_ptr[ch] = (m_ptr[ch] + 1) % MOD;
                end
`else
                m_wrap[ch] = (m_ptr[ch] + 1 >= MOD);
                m_ptr[ch]  = (m_ptr[ch] + 1) % MOD;
`endif
            end else if (dec[ch] && !inc[ch]) begin
`ifdef PTRBANK_WRAP_EN
                if (m_ptr[ch] == m_base[ch]) begin
                    m_ptr[ch]  = m_lim[ch];
                    m_wrap[ch] = 1;
                end else begin
                    m_ptr[ch] = (m_ptr[ch] + MOD - 1) % MOD;
                end
`else
                m_wrap[ch] = (m_ptr[ch] == 0);
                m_ptr[ch]  = (m_ptr[ch] + MOD - 1) % MOD;
`endif
            end
        end
    endfunction

    task automatic compare_all();
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("dout%0d", ch), ch_dout(ch), 32'(m_ptr[ch]));
            check($sformatf("wrap%0d", ch), 32'(wrap[ch]), 32'(m_wrap[ch]));
            check($sformatf("base_valid%0d", ch), 32'(base_valid[ch]), 32'(m_bv[ch]));
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare just after the edge
    task automatic cyc(input bit rst, input bit wen, input int wsel, input int wmode, input int data,
                       input bit [NCH-1:0] rew, input bit [NCH-1:0] inc, input bit [NCH-1:0] dec);
        RST    = rst;
        Wen    = wen;
        Wsel   = SEL_W'(wsel);
        Wmode  = 2'(wmode);
        BusOut = WIDTH'(data);
        Rew    = rew;
        Inc    = inc;
        Dec    = dec;
        @(posedge Clk);
        if (rst) model_reset();
        else     model_step(wen, wsel, wmode, data, rew, inc, dec);
        #1;
        compare_all();
    endtask

    task automatic wr(input int wsel, input int wmode, input int data);
        cyc(0, 1, wsel, wmode, data, '0, '0, '0);
    endtask

    task automatic idle_req(input bit [NCH-1:0] rew, input bit [NCH-1:0] inc, input bit [NCH-1:0] dec);
        cyc(0, 0, 0, 0, 0, rew, inc, dec);
    endtask

    function automatic int pick_data();
        case ($urandom % 6)
            0:       return 0;
            1:       return MOD - 1;
            2:       return MOD - 2;
            3:       return 1;
            default: return int'($urandom % MOD);
        endcase
    endfunction

    initial begin
        RST = 1'b1; Wen = 1'b0; Wsel = '0; Wmode = '0; BusOut = '0;
        Rew = '0; Inc = '0; Dec = '0;
        model_reset();

        // Reset state
        cyc(1, 0, 0, 0, 0, '0, '0, '0);
        cyc(1, 0, 0, 0, 0, '0, '0, '0);
        check("reset_dout_all", 32'(dout), 32'(0));
        check("reset_bv_all", 32'(base_valid), 32'(0));

        // First pointer load defines the base; second load keeps it
        wr(0, 0, 'h20);
        check("load0_dout", ch_dout(0), 32'h20);
        check("load0_bv", 32'(base_valid[0]), 32'(1));
        wr(0, 0, 'h40);
        check("load0_second", ch_dout(0), 32'h40);
        idle_req(3'b001, '0, '0);
        check("rew0_to_first", ch_dout(0), 32'h20);

        // Rewind with no base defined yields 0
        idle_req(3'b100, '0, '0);
        check("rew2_undefined", ch_dout(2), 32'h0);

`ifdef PTRBANK_WRAP_EN
        wr(1, 2, 'h05);
        check("lim_no_ptr_change", ch_dout(1), 32'h0);
        wr(1, 0, 'h03);
        idle_req('0, 3'b010, '0);
        check("inc1_a", ch_dout(1), 32'h04);
        check("inc1_a_wrap", 32'(wrap[1]), 32'(0));
        idle_req('0, 3'b010, '0);
        check("inc1_b", ch_dout(1), 32'h05);
        idle_req('0, 3'b010, '0);
        check("inc1_wrap_to_base", ch_dout(1), 32'h03);
        check("inc1_wrap_pulse", 32'(wrap[1]), 32'(1));
        idle_req('0, '0, 3'b010);
        check("dec1_wrap_to_lim", ch_dout(1), 32'h05);
        check("dec1_wrap_pulse", 32'(wrap[1]), 32'(1));
        idle_req('0, 3'b010, 3'b010);
        check("incdec_hold", ch_dout(1), 32'h05);
        check("incdec_no_wrap", 32'(wrap[1]), 32'(0));
`else
        wr(1, 0, 'hFF);
        idle_req('0, 3'b010, '0);
        check("roll_inc", ch_dout(1), 32'h00);
        check("roll_inc_wrap", 32'(wrap[1]), 32'(1));
        wr(1, 2, 'h77);
        check("lim_write_nop", ch_dout(1), 32'h00);
        check("lim_write_no_wrap", 32'(wrap[1]), 32'(0));
        idle_req('0, '0, 3'b010);
        check("roll_dec", ch_dout(1), 32'hFF);
        check("roll_dec_wrap", 32'(wrap[1]), 32'(1));
        idle_req('0, 3'b010, 3'b010);
        check("incdec_hold", ch_dout(1), 32'hFF);
        check("incdec_no_wrap", 32'(wrap[1]), 32'(0));
`endif

        // Write beats Rew on ch0 while ch1 increments in the same cycle
        cyc(0, 1, 0, 0, 'h55, 3'b001, 3'b010, '0);
        check("write_beats_rew", ch_dout(0), 32'h55);

        // Reset in the middle of an Inc burst clears everything, including a pending wrap
        idle_req('0, 3'b011, '0);
        idle_req('0, 3'b011, '0);
        cyc(1, 0, 0, 0, 0, '0, 3'b011, '0);
        check("rst_mid_dout", 32'(dout), 32'(0));
        check("rst_mid_wrap", 32'(wrap), 32'(0));
        check("rst_mid_bv", 32'(base_valid), 32'(0));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit          rst, wen;
            int          wsel, wmode, data;
            bit [NCH-1:0] rew, inc, dec;
            rst   = ($urandom % 80) == 0;
            wen   = ($urandom % 3) == 0;
            wsel  = int'($urandom % 4);
            wmode = int'($urandom % 4);
            data  = pick_data();
            rew   = '0;
            inc   = '0;
            dec   = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                rew[ch] = ($urandom % 10) == 0;
                inc[ch] = ($urandom % 2) == 0;
                dec[ch] = ($urandom % 4) == 0;
            end
            // Keep channel requests away from writes that change nothing
            if (wen && (wsel >= NCH || !write_exists(wmode))) begin
                rew = '0;
                inc = '0;
                dec = '0;
            end
            cyc(rst, wen, wsel, wmode, data, rew, inc, dec);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
